// File: rtl/openmips_pkg.sv
// Shared constants for the openMIPS architectural state blocks.
// Imported by hilo_reg and regfile_hilo.
package openmips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] ZERO_WORD = 32'h0;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO register pair written atomically from writeback.
// Ports: clk, rst_n (async active-low), we, wdata_hi/lo in; hi/lo out.
// Macro REGFILE_BYPASS_EN forwards the incoming pair in the write cycle.
module hilo_reg
    import openmips_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [W-1:0] wdata_hi,
    input  logic [W-1:0] wdata_lo,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (we) begin
            hi_q <= wdata_hi;
            lo_q <= wdata_lo;
        end
    end

    always_comb begin
        hi = hi_q;
        lo = lo_q;
`ifdef REGFILE_BYPASS_EN
        if (we) begin
            hi = wdata_hi;
            lo = wdata_lo;
        end
`endif
        // Bypassed data must not leak out while reset is held.
        if (!rst_n) begin
            hi = '0;
            lo = '0;
        end
    end

endmodule

// File: rtl/regfile_hilo.sv
// GPR file (r0 hard-wired to zero) plus HI/LO pair, writeback sink.
// Ports: clk, rst_n, GPR write (we/waddr/wdata), two read ports
// (reN/raddrN -> rdataN), HI/LO write (we_hilo/wdata_hi/lo) -> hi/lo.
// Macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_hilo
    import openmips_pkg::*;
#(
    parameter int DATA_W = openmips_pkg::DATA_W,
    parameter int ADDR_W = openmips_pkg::ADDR_W,
    parameter int NREG   = openmips_pkg::NREG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rf_i_we,
    input  logic [ADDR_W-1:0] rf_i_waddr,
    input  logic [DATA_W-1:0] rf_i_wdata,
    input  logic              rf_i_re1,
    input  logic [ADDR_W-1:0] rf_i_raddr1,
    input  logic              rf_i_re2,
    input  logic [ADDR_W-1:0] rf_i_raddr2,
    input  logic              rf_i_we_hilo,
    input  logic [DATA_W-1:0] rf_i_wdata_hi,
    input  logic [DATA_W-1:0] rf_i_wdata_lo,
    output logic [DATA_W-1:0] rf_o_rdata1,
    output logic [DATA_W-1:0] rf_o_rdata2,
    output logic [DATA_W-1:0] rf_o_hi,
    output logic [DATA_W-1:0] rf_o_lo
);

    localparam logic [ADDR_W-1:0] R0 = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_ok;

    assign wr_ok = rf_i_we && (rf_i_waddr != R0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[rf_i_waddr] <= rf_i_wdata;
        end
    end

    always_comb begin
        rf_o_rdata1 = '0;
        if (rst_n && rf_i_re1 && (rf_i_raddr1 != R0)) begin
            rf_o_rdata1 = regs[rf_i_raddr1];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (rf_i_raddr1 == rf_i_waddr)) begin
                rf_o_rdata1 = rf_i_wdata;
            end
`endif
        end
    end

    always_comb begin
        rf_o_rdata2 = '0;
        if (rst_n && rf_i_re2 && (rf_i_raddr2 != R0)) begin
            rf_o_rdata2 = regs[rf_i_raddr2];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (rf_i_raddr2 == rf_i_waddr)) begin
                rf_o_rdata2 = rf_i_wdata;
            end
`endif
        end
    end

    hilo_reg #(
        .W (DATA_W)
    ) u_hilo (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_i_we_hilo),
        .wdata_hi (rf_i_wdata_hi),
        .wdata_lo (rf_i_wdata_lo),
        .hi       (rf_o_hi),
        .lo       (rf_o_lo)
    );

endmodule

// File: tb/tb_regfile_hilo.sv
// Directed bench for regfile_hilo; inputs change on negedge,
// outputs are checked mid low phase, before the next rising edge.
module tb_regfile_hilo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic        we_hilo;
    logic [31:0] wdata_hi, wdata_lo;
    logic [31:0] rdata1, rdata2, hi, lo;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    regfile_hilo dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rf_i_we       (we),
        .rf_i_waddr    (waddr),
        .rf_i_wdata    (wdata),
        .rf_i_re1      (re1),
        .rf_i_raddr1   (raddr1),
        .rf_i_re2      (re2),
        .rf_i_raddr2   (raddr2),
        .rf_i_we_hilo  (we_hilo),
        .rf_i_wdata_hi (wdata_hi),
        .rf_i_wdata_lo (wdata_lo),
        .rf_o_rdata1   (rdata1),
        .rf_o_rdata2   (rdata2),
        .rf_o_hi       (hi),
        .rf_o_lo       (lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;
        we_hilo = 1'b0; wdata_hi = '0; wdata_lo = '0;
        #2;
        re1 = 1'b1; raddr1 = 5'd1; re2 = 1'b1; raddr2 = 5'd31;
        #1;
        chk("reset_rd1", rdata1, 32'h0);
        chk("reset_hi", hi, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Arbitrary writes, then asynchronous reset before any edge.
        we = 1'b1; waddr = 5'd1; wdata = 32'h11;
        we_hilo = 1'b1; wdata_hi = 32'hAA; wdata_lo = 32'hBB;
        @(negedge clk) waddr = 5'd31; wdata = 32'hF1; we_hilo = 1'b0;
        @(negedge clk) we = 1'b0;
        #2;
        chk("pre_rst_r1", rdata1, 32'h11);
        chk("pre_rst_r31", rdata2, 32'hF1);
        chk("pre_rst_lo", lo, 32'hBB);
        rst_n = 1'b0;
        #1;
        chk("async_rst_r1", rdata1, 32'h0);
        chk("async_rst_r31", rdata2, 32'h0);
        chk("async_rst_hi", hi, 32'h0);
        chk("async_rst_lo", lo, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        #2;
        chk("post_rst_r1", rdata1, 32'h0);
        chk("post_rst_r31", rdata2, 32'h0);

        // r0 protection.
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF;
        re1 = 1'b1; raddr1 = 5'd0;
        #2 chk("r0_same_cycle", rdata1, 32'h0);
        @(negedge clk) we = 1'b0;
        #2 chk("r0_after", rdata1, 32'h0);

        // Write / read back on both ports, read enable gating.
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'h12345678;
        re1 = 1'b0; re2 = 1'b0;
        @(negedge clk);
        we = 1'b0;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        #2;
        chk("rb_port1", rdata1, 32'h12345678);
        chk("rb_port2", rdata2, 32'h12345678);
        re1 = 1'b0;
        #1 chk("re1_off", rdata1, 32'h0);
        chk("re1_off_p2", rdata2, 32'h12345678);

        // Back-to-back writes: last wins.
        @(negedge clk) we = 1'b1; waddr = 5'd5; wdata = 32'h1111;
        @(negedge clk) wdata = 32'h2222;
        @(negedge clk) we = 1'b0; wdata = 32'h3333;
        #2 chk("b2b_last", rdata2, 32'h2222);
        @(negedge clk) waddr = 5'd6;
        #2 chk("we0_nochg", rdata2, 32'h2222);

        // Same-cycle RAW on port 2.
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        re2 = 1'b1; raddr2 = 5'd7;
        #2 chk("raw_same", rdata2, BYP ? 32'hA5A5A5A5 : 32'h0);
        @(negedge clk) we = 1'b0;
        #2 chk("raw_next", rdata2, 32'hA5A5A5A5);

        // HI/LO write with simultaneous GPR write.
        @(negedge clk);
        we_hilo = 1'b1; wdata_hi = 32'h1; wdata_lo = 32'hFFFFFFFF;
        we = 1'b1; waddr = 5'd3; wdata = 32'h3;
        re1 = 1'b1; raddr1 = 5'd3;
        #2;
        chk("hi_same", hi, BYP ? 32'h1 : 32'h0);
        chk("lo_same", lo, BYP ? 32'hFFFFFFFF : 32'h0);
        @(negedge clk);
        we = 1'b0; we_hilo = 1'b0;
        wdata_hi = 32'h2; wdata_lo = 32'h4;
        #2;
        chk("hi_next", hi, 32'h1);
        chk("lo_next", lo, 32'hFFFFFFFF);
        chk("r3_next", rdata1, 32'h3);
        @(negedge clk);
        #2;
        chk("hi_hold", hi, 32'h1);
        chk("lo_hold", lo, 32'hFFFFFFFF);

        // Reset coincident with a write to r9.
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        re1 = 1'b1; raddr1 = 5'd9;
        #2 rst_n = 1'b0;
        #1 chk("rst_wr_during", rdata1, 32'h0);
        @(negedge clk) we = 1'b0; rst_n = 1'b1;
        #2;
        chk("rst_wr_r9", rdata1, 32'h0);
        chk("rst_wr_hi", hi, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_hilo.md
Name: regfile_hilo

Overview:
- Architectural state sink for the writeback stage of the openMIPS pipeline.
- Holds the 32-entry GPR file and the HI/LO pair.
- Accepts one GPR write and one HI/LO write per cycle from writeback.
- Serves two GPR read ports to decode and one HI/LO read to execute. Same-cycle write-to-read forwarding is included when compiled in.

Parameters:
DATA_W, 32, data width of GPRs and HI/LO
ADDR_W, 5, GPR address width
NREG, 32, number of GPRs (must equal 2**ADDR_W)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rf_i_we  in  1  GPR write enable (from writeback wreg)
rf_i_waddr  in  ADDR_W  GPR write address
rf_i_wdata  in  DATA_W  GPR write data
rf_i_re1  in  1  read port 1 enable
rf_i_raddr1  in  ADDR_W  read port 1 address
rf_i_re2  in  1  read port 2 enable
rf_i_raddr2  in  ADDR_W  read port 2 address
rf_i_we_hilo  in  1  HI/LO write enable (from writeback)
rf_i_wdata_hi  in  DATA_W  HI write data
rf_i_wdata_lo  in  DATA_W  LO write data
rf_o_rdata1  out  DATA_W  read port 1 data
rf_o_rdata2  out  DATA_W  read port 2 data
rf_o_hi  out  DATA_W  current HI
rf_o_lo  out  DATA_W  current LO

Behaviour:
- Reset is asynchronous, active-low, on a single clock.
- While rst_n=0:
  - all GPRs, HI and LO clear to 0 immediately, without waiting for a clock edge;
  - all outputs read 0;
  - writes are ignored.
- Reset deassertion is synchronised externally. The first write is accepted at the first rising edge with rst_n=1.
- GPR write: at a rising edge with rf_i_we=1 and rf_i_waddr!=0, regs[waddr] <= wdata. Writes to r0 are dropped; r0 always reads 0.
- GPR read: combinational, zero-cycle latency.
  - rf_o_rdataN = 0 if reN=0 or raddrN=0.
  - Otherwise, if the bypass condition holds (see Optional Feature), rf_o_rdataN = rf_i_wdata.
  - Otherwise rf_o_rdataN = regs[raddrN].
- Both read ports are fully independent. The same address on both ports returns identical data.
- HI/LO write: at a rising edge with rf_i_we_hilo=1, HI <= wdata_hi and LO <= wdata_lo, atomically as a pair. No partial write exists.
- HI/LO read: rf_o_hi and rf_o_lo reflect the registered value, or the bypassed value when the feature is enabled.
- Simultaneous GPR and HI/LO writes in one cycle are both committed; the two are independent.
- Write with rf_i_we=0 and any address: no state change.
- Reset asserted mid-cycle coincident with a write: reset wins and the write is lost.
- There are no stalls or handshakes. A write is accepted every cycle that its enable is high. Back-to-back writes to the same register: the last write wins.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If rf_i_we=1, rf_i_waddr!=0, reN=1 and raddrN==rf_i_waddr, rf_o_rdataN = rf_i_wdata in the same cycle.
  - If rf_i_we_hilo=1, rf_o_hi/rf_o_lo = rf_i_wdata_hi/rf_i_wdata_lo in the same cycle.
  - This closes the decode-vs-writeback RAW hazard.
- Undefined:
  - Reads return only registered state. The new value is visible from the cycle after the write edge.
  - The pipeline forwarding network must then cover the writeback distance.

Decomposition:
- Shared package openmips_pkg holds:
  - DATA_W, ADDR_W, NREG constants;
  - REG_ZERO (5'd0) address constant;
  - ZERO_WORD (32'h0) constant.
- One natural sub-module, hilo_reg, contains:
  - the HI/LO pair and its write enable;
  - the HI/LO half of the bypass mux.
- The GPR array and the read muxes remain in regfile_hilo.

Test Plan:
- Reset: drive rst_n=0 after arbitrary writes; check r1..r31, HI and LO read 0 asynchronously, before any clock edge.
- r0 protection: write we=1, waddr=0, wdata=32'hDEADBEEF, then read raddr1=0 → rdata1=0.
- Write/read-back: write r5=32'h12345678, then read both ports at 5 the next cycle → both 32'h12345678. Read with re1=0 → rdata1=0.
- Same-cycle RAW: write r7=32'hA5A5A5A5 while raddr2=7, re2=1 → rdata2=32'hA5A5A5A5 in that cycle with REGFILE_BYPASS_EN; old value (0) without it, then 32'hA5A5A5A5 the next cycle.
- HI/LO: we_hilo=1, hi=32'h1, lo=32'hFFFFFFFF, plus a simultaneous GPR write r3=32'h3 → the next cycle shows hi=1, lo=FFFFFFFF, r3=3. Then we_hilo=0 with new data → hi/lo unchanged.
- Reset mid-operation: assert rst_n=0 in the same cycle as a write to r9=32'h99 → r9 reads 0 after reset release.
